// File: rtl/sram_c_drain.sv
// rtl/sram_c_drain.sv - burst read-out of sram_C into a valid/ready byte stream
// Defining DRAIN_CHKSUM_EN appends a mod-2^DATA_W sum trailer byte to every run.
module sram_c_drain #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              sram_ce,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
`ifdef DRAIN_CHKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W:0]    issue_q, issue_d;
  logic [ADDR_W:0]    accept_q, accept_d;
  logic               inflight_q, inflight_d;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
`ifdef DRAIN_CHKSUM_EN
  logic [DATA_W-1:0]  sum_q, sum_d;
`endif

  logic              fifo_push;
  logic              fifo_pop;
  logic              flush;
  logic [DATA_W-1:0] fifo_head;

  assign fifo_head = mem_q[rd_ptr_q];
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign sram_addr = addr_q;

`ifdef DRAIN_CHKSUM_EN
  assign out_valid = (count_q != '0) || (state_q == S_CHK);
  assign out_data  = (state_q == S_CHK) ? sum_q : fifo_head;
`else
  assign out_valid = (count_q != '0);
  assign out_data  = fifo_head;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issue_d    = issue_q;
    accept_d   = accept_q;
    sram_ce    = 1'b0;
    flush      = 1'b0;
    fifo_pop   = 1'b0;
    fifo_push  = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
`ifdef DRAIN_CHKSUM_EN
    sum_d      = sum_q;
`endif

    // Credit: FIFO slots already taken plus the read still returning.
    if (state_q == S_RUN && issue_q != '0 &&
        (count_q + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH)) begin
      sram_ce = 1'b1;
    end
    if ((state_q == S_RUN || state_q == S_DRAIN) && count_q != '0 && out_ready) begin
      fifo_pop = 1'b1;
    end
    inflight_d = sram_ce;

    if (sram_ce) begin
      addr_d  = addr_q + ADDR_ONE;
      issue_d = issue_q - LEN_ONE;
    end
    if (fifo_pop) begin
      accept_d = accept_q - LEN_ONE;
`ifdef DRAIN_CHKSUM_EN
      sum_d    = sum_q + fifo_head;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          issue_d  = length;
          accept_d = length;
`ifdef DRAIN_CHKSUM_EN
          sum_d    = '0;
          state_d  = (length == '0) ? S_CHK : S_RUN;
`else
          state_d  = (length == '0) ? S_DONE : S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (issue_d == '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
`ifdef DRAIN_CHKSUM_EN
        if (accept_d == '0) state_d = S_CHK;
`else
        if (accept_d == '0) state_d = S_DONE;
`endif
      end
`ifdef DRAIN_CHKSUM_EN
      S_CHK: begin
        if (out_ready) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort drops everything, including a read returning this cycle.
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      issue_d    = '0;
      accept_d   = '0;
      inflight_d = 1'b0;
      flush      = 1'b1;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
`ifdef DRAIN_CHKSUM_EN
      sum_d      = '0;
`endif
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fifo_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (fifo_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      issue_q    <= '0;
      accept_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
`ifdef DRAIN_CHKSUM_EN
      sum_q      <= '0;
`endif
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      accept_q   <= accept_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
`ifdef DRAIN_CHKSUM_EN
      sum_q      <= sum_d;
`endif
      if (fifo_push) begin
        mem_q[wr_ptr_q] <= sram_dout;
      end
    end
  end

endmodule

// File: tb/tb_sram_c_drain.sv
// tb/tb_sram_c_drain.sv - scoreboard bench for sram_c_drain
// Expected bytes come from a memory array and per-run queue; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_sram_c_drain;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int MEM_N  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              abort;
  logic              busy;
  logic              done;
  logic              sram_ce;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dout = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  sram_c_drain #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .busy(busy), .done(done), .sram_ce(sram_ce), .sram_addr(sram_addr),
    .sram_dout(sram_dout), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [MEM_N];
  always @(posedge clk) if (sram_ce) sram_dout <= mem[sram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int done_due = -1;
  int issued = 0, accepted = 0, ce_total = 0, done_cnt = 0;
  int rdy_mode = 0;
  logic [ADDR_W-1:0] cur_base = '0;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_byte;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and polices done, stalls and credits.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        issued = 0;
        accepted = 0;
      end else begin
        if (done) done_cnt++;
        if (done || cyc == done_due) chk("done_timing", done, cyc == done_due);
        if (prev_stall && busy) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, prev_data);
        end
        if (!busy) begin
          issued = 0;
          accepted = 0;
        end
        if (sram_ce) begin
          chk("ce_only_busy", busy, 1);
          chk("ce_credit", (issued - accepted) < DEPTH, 1);
          exp_addr = cur_base + issued[ADDR_W-1:0];
          chk("sram_addr", sram_addr, exp_addr);
          issued++;
          ce_total++;
        end
        if (out_valid && out_ready && !(abort && busy)) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_byte: got 0x%0h with no byte expected (cycle %0d)", out_data, cyc);
          end else begin
            exp_byte = exp_q.pop_front();
            if (out_data !== exp_byte) begin
              errors++;
              $display("FAIL out_data: got 0x%0h, expected 0x%0h (cycle %0d)", out_data, exp_byte, cyc);
            end
            accepted++;
            if (exp_q.size() == 0) done_due = cyc + 1;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  // Consumer: 0 always ready, 1 pattern 1,0,0, 2 random, 3 hold low, other = driven by test.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
        2: out_ready = 1'($urandom_range(0, 1));
        3: out_ready = 1'b0;
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_run(input logic [ADDR_W-1:0] b, input int len);
    logic [ADDR_W-1:0] a;
`ifdef DRAIN_CHKSUM_EN
    logic [DATA_W-1:0] s;
    s = '0;
`endif
    for (int i = 0; i < len; i++) begin
      a = b + i[ADDR_W-1:0];
      exp_q.push_back(mem[a]);
`ifdef DRAIN_CHKSUM_EN
      s = s + mem[a];
`endif
    end
`ifdef DRAIN_CHKSUM_EN
    exp_q.push_back(s);
`else
    if (len == 0) done_due = cyc + 1;
`endif
    cur_base  = b;
    base_addr = b;
    length    = len[ADDR_W:0];
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("idle_within_budget", busy, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sram_ce"}, sram_ce, 0);
    chk({tag, "_sram_addr"}, sram_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int ce0, d0, k, len;
    logic [ADDR_W-1:0] b;
    rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    for (int i = 0; i < MEM_N; i++) mem[i] = 8'($urandom);
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic run with latency and read-count checks.
    mem[10'h010] = 8'h11; mem[10'h011] = 8'h22; mem[10'h012] = 8'h33; mem[10'h013] = 8'h44;
    rdy_mode = 0;
    ce0 = ce_total; d0 = done_cnt;
    start_run(10'h010, 4);
    chk("lat_busy", busy, 1);
    chk("lat_cycle1_valid", out_valid, 0);
    tick();
    chk("lat_cycle2_valid", out_valid, 0);
    tick();
    chk("lat_cycle3_valid", out_valid, 1);
    chk("lat_cycle3_data", out_data, 8'h11);
    wait_idle(50);
    chk("len4_ce_count", ce_total - ce0, 4);
    chk("len4_done_pulses", done_cnt - d0, 1);

    // Same data under a 1,0,0 back-pressure pattern.
    rdy_mode = 1;
    ce0 = ce_total;
    start_run(10'h010, 4);
    wait_idle(100);
    chk("stall_ce_count", ce_total - ce0, 4);

    // Address wrap.
    mem[10'h3FF] = 8'hA0; mem[10'h000] = 8'hA1; mem[10'h001] = 8'hA2;
    rdy_mode = 0;
    start_run(10'h3FF, 3);
    wait_idle(50);

    // Zero length.
    ce0 = ce_total; d0 = done_cnt;
    start_run(10'h123, 0);
    chk("len0_busy", busy, 1);
    wait_idle(20);
    chk("len0_no_reads", ce_total - ce0, 0);
    chk("len0_done_pulses", done_cnt - d0, 1);

    // Abort after three accepted bytes with the consumer stalled.
    rdy_mode = 4;
    out_ready = 1'b1;
    start_run(10'h100, 8);
    k = 0;
    for (int i = 0; i < 100 && k < 3; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) k++;
    end
    chk("abort_three_accepted", k, 3);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (2) tick();
    d0 = done_cnt;
    abort = 1'b1;
    exp_q.delete();
    done_due = -1;
    tick();
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (5) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    rdy_mode = 2;
    start_run(10'h200, 5);
    wait_idle(200);

    // Checksum example bytes.
    mem[10'h040] = 8'hFF; mem[10'h041] = 8'h02; mem[10'h042] = 8'h10;
    rdy_mode = 1;
    start_run(10'h040, 3);
    wait_idle(100);

    // Randomized runs, with ignored starts issued while busy.
    for (int r = 0; r < 25; r++) begin
      rdy_mode = $urandom_range(0, 2);
      b = ADDR_W'($urandom);
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(13, 40) : $urandom_range(0, 12);
      start_run(b, len);
      if ($urandom_range(0, 1) == 1 && busy) begin
        start = 1'b1;
        base_addr = ADDR_W'($urandom);
        length = (ADDR_W+1)'($urandom_range(1, 30));
        tick();
        start = 1'b0;
      end
      wait_idle(600);
    end

    // Reset in the middle of a run.
    rdy_mode = 3;
    tick();
    start_run(10'h300, 10);
    repeat (4) tick();
    rst = 1'b1;
    exp_q.delete();
    done_due = -1;
    tick();
    check_reset_outputs("midrun_reset");
    rst = 1'b0;
    rdy_mode = 0;
    tick();
    start_run(10'h300, 6);
    wait_idle(60);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
